fsm_ones_counter: RTL
=====================

// Module: fsm_ones_counter
// PURPOSE
//  Parametrised, multi-channel successor to the fixed 4-count data FSM. Each channel counts
//  cycles with data high (zeros hold the count) and pulses flag when a runtime threshold is hit.
//  Adds wrap or one-shot mode, sync clear and enable. Sits in the niuke FSM exercise set.
// PARAMETERS
//  NUM_CH   1   independent channels
//  CNT_W    3   width of thresh and the per-channel counter
//  DEF_TH   4   threshold used when thresh input is 0 (must be >=1, <2**CNT_W)
// PORTS
//  clk     in   1               rising-edge clock
//  rst     in   1               asynchronous reset, active-high
//  en      in   1               count enable, all channels
//  clr     in   1               synchronous clear, all channels
//  mode    in   1               0=wrap (restart after hit), 1=one-shot (halt in DONE until clr)
//  thresh  in   CNT_W           ones per hit; 0 selects DEF_TH
//  data    in   NUM_CH          per-channel input bit
//  flag    out  NUM_CH          registered 1-cycle hit pulse
//  done    out  NUM_CH          registered level; high while channel is in DONE
//  cnt     out  NUM_CH*CNT_W    per-channel count, ch0 in LSBs (only with FSM_CNT_OBS_EN)
// BEHAVIOUR
//  - rst high (any time, mid-count too): state=ST_CNT, cnt=0, flag=0, done=0 immediately.
//  - Per-channel states: ST_CNT (counting), ST_DONE (one-shot halted). Encoding in the package.
//  - th_eff = (thresh==0) ? DEF_TH : thresh; sampled every cycle (no latching).
//  - Priority per edge: rst > clr > !en > count logic.
//  - clr: cnt<=0, state<=ST_CNT, flag<=0, done<=0; data that cycle discarded.
//  - en=0: cnt/state hold, flag<=0.
//  - ST_CNT, en=1, data=0: hold cnt, flag<=0.
//  - ST_CNT, en=1, data=1, cnt+1 < th_eff: cnt<=cnt+1, flag<=0.
//  - ST_CNT, en=1, data=1, cnt+1 >= th_eff (hit): flag<=1, cnt<=0;
//    mode=0 -> stay ST_CNT; mode=1 -> ST_DONE, done<=1.
//  - ">=" covers thresh lowered mid-count: next one hits at once. Compare at CNT_W+1 bits, no wrap.
//  - Latency: hit sample at edge k -> flag high in the cycle after edge k, for exactly one cycle.
//  - th_eff=1: flag high the cycle after every enabled data=1 sample.
//  - ST_DONE: data and en ignored, flag=0, done=1, cnt=0; only clr or rst leave it.
//  - mode change mid-count takes effect at the next hit; mode=0 in ST_DONE does not release it.
//  - Channels share en/clr/mode/thresh and are otherwise fully independent.
// CONFIGURATION
//  - FSM_CNT_OBS_EN defined: port cnt present, driven from the per-channel count registers.
//  - Undefined: port cnt absent; counting, flag and done unchanged.
// STRUCTURE
//  - Package fsm_ones_counter_pkg: state typedef/encodings (ST_CNT, ST_DONE), MODE_WRAP=0,
//    MODE_ONESHOT=1.
//  - Sub-module fsm_ones_counter_ch: one channel (state reg, counter, flag/done regs).
//    Top does the th_eff select and a generate loop over NUM_CH.
// TESTING (NUM_CH=2, CNT_W=3, DEF_TH=4 unless noted)
//  1. thresh=0, mode=0, en=1, data[0]=1 for 8 cycles -> flag[0] pulses after 4th and 8th samples.
//  2. data[0]=1,0,1,1,0,0,1 with thresh=4 -> single flag pulse after 7th sample; zeros hold count.
//  3. mode=1, thresh=2, data[0]=1 for 6 cycles -> one flag pulse, done[0]=1 stays;
//     clr -> done=0, counting resumes.
//  4. thresh=5, 3 ones, then thresh=2, one more one -> immediate hit (>= rule), cnt back to 0.
//  5. clr together with data=1 at cnt=3 -> no flag, cnt=0; rst asserted mid-count ->
//     all outputs 0 without a clock edge.
//  6. thresh=1, data=2'b01 alternating with 2'b10, en toggled -> per-channel flags independent;
//     no flag while en=0.

Source files
------------

// File: rtl/fsm_ones_counter_pkg.sv
// Shared state encoding and mode constants for the per-channel ones counter.
package fsm_ones_counter_pkg;

  typedef enum logic {
    ST_CNT  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/fsm_ones_counter_ch.sv
// One counting channel: state, counter and registered flag/done outputs.
// The o_cnt observation port exists only when FSM_CNT_OBS_EN is defined.
module fsm_ones_counter_ch
  import fsm_ones_counter_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_mode,
  input  logic [CNT_W-1:0] i_th_eff,
  input  logic             i_data,
  output logic             o_flag,
  output logic             o_done
`ifdef FSM_CNT_OBS_EN
  ,
  output logic [CNT_W-1:0] o_cnt
`endif
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flag;
  logic             r_done;

  logic [CNT_W:0]   w_next;
  logic             w_hit;

  // One extra bit so cnt+1 never wraps below a lowered threshold.
  assign w_next = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign w_hit  = (w_next >= {1'b0, i_th_eff});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CNT;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_clr) begin
      r_state <= ST_CNT;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
      r_done  <= 1'b0;
    end else if (!i_en) begin
      r_flag <= 1'b0;
    end else begin
      case (r_state)
        ST_CNT: begin
          if (i_data && w_hit) begin
            r_flag <= 1'b1;
            r_cnt  <= '0;
            if (i_mode == MODE_ONESHOT) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else if (i_data) begin
            r_cnt  <= w_next[CNT_W-1:0];
            r_flag <= 1'b0;
          end else begin
            r_flag <= 1'b0;
          end
        end
        ST_DONE: begin
          r_flag <= 1'b0;
          r_done <= 1'b1;
          r_cnt  <= '0;
        end
        default: begin
          r_state <= ST_CNT;
          r_cnt   <= '0;
          r_flag  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_flag = r_flag;
  assign o_done = r_done;
`ifdef FSM_CNT_OBS_EN
  assign o_cnt  = r_cnt;
`endif

endmodule

// File: rtl/fsm_ones_counter.sv
// Multi-channel ones counter: threshold select plus one channel instance per data bit.
// Define FSM_CNT_OBS_EN to expose the per-channel count registers on port cnt.
module fsm_ones_counter
  import fsm_ones_counter_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int CNT_W  = 3,
  parameter int DEF_TH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    mode,
  input  logic [CNT_W-1:0]        thresh,
  input  logic [NUM_CH-1:0]       data,
  output logic [NUM_CH-1:0]       flag,
  output logic [NUM_CH-1:0]       done
`ifdef FSM_CNT_OBS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] cnt
`endif
);

  localparam logic [CNT_W-1:0] DEF_TH_V = CNT_W'(DEF_TH);

  logic [CNT_W-1:0] w_th_eff;

  // Threshold is re-evaluated every cycle; zero falls back to the default.
  assign w_th_eff = (thresh == '0) ? DEF_TH_V : thresh;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fsm_ones_counter_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_en    (en),
      .i_clr   (clr),
      .i_mode  (mode),
      .i_th_eff(w_th_eff),
      .i_data  (data[g]),
      .o_flag  (flag[g]),
      .o_done  (done[g])
`ifdef FSM_CNT_OBS_EN
      ,
      .o_cnt   (cnt[g*CNT_W +: CNT_W])
`endif
    );
  end

endmodule
